// File: rtl/router_port_ctrl.sv
// 1x3 router port controller: latches the packet destination, steers the FSM write
// enable to the addressed FIFO, and soft-resets any FIFO whose data sits unread too long.

module router_port_timeout #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stalled;

  assign stalled = vld & ~read_enb;

  // Counter restarts on wrap so a FIFO left stalled pulses every TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!stalled) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LIMIT) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end
endmodule

module router_port_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);
  localparam int NUM_PORTS = 3;

  logic [1:0]           addr_q;
  logic [NUM_PORTS-1:0] empty, read_enb, full, vld, soft_reset;

  assign empty    = {empty_2, empty_1, empty_0};
  assign read_enb = {read_enb_2, read_enb_1, read_enb_0};
  assign full     = {full_2, full_1, full_0};
  assign vld      = ~empty;

  assign {vld_out_2, vld_out_1, vld_out_0}          = vld;
  assign {soft_reset_2, soft_reset_1, soft_reset_0} = soft_reset;

  // Address 3 is a legal latch value meaning "no port"; it is also the reset value.
  always_ff @(posedge clk) begin
    if (!rst)            addr_q <= 2'b11;
    else if (detect_add) addr_q <= data_in;
  end

  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr_q)
      2'd0: begin write_enb = {2'b00, write_enb_reg}; fifo_full = full[0]; end
      2'd1: begin write_enb = {1'b0, write_enb_reg, 1'b0}; fifo_full = full[1]; end
      2'd2: begin write_enb = {write_enb_reg, 2'b00}; fifo_full = full[2]; end
      default: ;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    router_port_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
      .clk       (clk),
      .rst       (rst),
      .vld       (vld[p]),
      .read_enb  (read_enb[p]),
      .soft_reset(soft_reset[p])
    );
  end
endmodule

// File: tb/tb_router_port_ctrl.sv
// Directed bench for router_port_ctrl: the driver queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.

module tb_router_port_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  typedef struct {
    string      nm;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vo;
    logic [2:0] sr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 1'b0;

  always #5 clk = ~clk;

  router_port_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2)
  );

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue the outputs expected for the inputs just driven, then advance one cycle.
  task automatic step(input string nm, input logic [2:0] we, input logic ff,
                      input logic [2:0] sr);
    exp_t e;
    e.nm = nm;
    e.we = we;
    e.ff = ff;
    e.vo = ~{empty_2, empty_1, empty_0};
    e.sr = sr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".write_enb"}, write_enb, e.we);
        chk({e.nm, ".fifo_full"}, {2'b00, fifo_full}, {2'b00, e.ff});
        chk({e.nm, ".vld_out"}, {vld_out_2, vld_out_1, vld_out_0}, e.vo);
        chk({e.nm, ".soft_reset"}, {soft_reset_2, soft_reset_1, soft_reset_0}, e.sr);
      end
    end
  end

  initial begin : driver
    rst = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;
    @(posedge clk);
    #1;

    // reset and idle
    step("reset0", 3'b000, 1'b0, 3'b000);
    step("reset1", 3'b000, 1'b0, 3'b000);
    rst = 1'b1;

    // address latch and steering: new address applies the cycle after detect
    detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b1;
    step("det1", 3'b000, 1'b0, 3'b000);
    detect_add = 1'b0;
    step("steer1", 3'b010, 1'b0, 3'b000);
    full_1 = 1'b1;
    step("full1", 3'b010, 1'b1, 3'b000);
    full_1 = 1'b0; full_0 = 1'b1;
    step("full0_unsel", 3'b010, 1'b0, 3'b000);
    detect_add = 1'b1; data_in = 2'd0;
    step("det0_old", 3'b010, 1'b0, 3'b000);
    detect_add = 1'b0;
    step("steer0", 3'b001, 1'b1, 3'b000);
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b0; full_2 = 1'b1;
    step("det2_nowr", 3'b000, 1'b1, 3'b000);
    detect_add = 1'b0; write_enb_reg = 1'b1;
    step("steer2", 3'b100, 1'b1, 3'b000);
    detect_add = 1'b1; data_in = 2'd3;
    step("det3_old", 3'b100, 1'b1, 3'b000);
    detect_add = 1'b0;
    step("noport", 3'b000, 1'b0, 3'b000);
    {full_2, full_1, full_0} = 3'b000; write_enb_reg = 1'b0;
    step("idle_a", 3'b000, 1'b0, 3'b000);

    // port 0 stalled continuously: pulses at cycles 30 and 60
    empty_0 = 1'b0;
    for (int i = 0; i < 65; i++)
      step("tmo0", 3'b000, 1'b0, (i == 30 || i == 60) ? 3'b001 : 3'b000);
    empty_0 = 1'b1;
    step("idle_b", 3'b000, 1'b0, 3'b000);

    // port 2 read once after 29 stalled cycles: counter restarts
    empty_2 = 1'b0;
    for (int i = 0; i < 62; i++) begin
      read_enb_2 = (i == 29);
      step("rescue2", 3'b000, 1'b0, (i == 60) ? 3'b100 : 3'b000);
    end
    read_enb_2 = 1'b0; empty_2 = 1'b1;
    step("idle_c", 3'b000, 1'b0, 3'b000);

    // ports 0 and 2 time out together, port 1 empty
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int i = 0; i < 32; i++)
      step("conc", 3'b000, 1'b0, (i == 30) ? 3'b101 : 3'b000);
    empty_0 = 1'b1; empty_2 = 1'b1;
    step("idle_d", 3'b000, 1'b0, 3'b000);

    // reset at stall count 20 with port 2 addressed
    detect_add = 1'b1; data_in = 2'd2;
    step("det2b", 3'b000, 1'b0, 3'b000);
    detect_add = 1'b0; write_enb_reg = 1'b1; empty_0 = 1'b0;
    for (int i = 0; i < 20; i++)
      step("pre_rst", 3'b100, 1'b0, 3'b000);
    rst = 1'b0;
    step("mid_rst", 3'b100, 1'b0, 3'b000);
    rst = 1'b1;
    for (int i = 21; i < 53; i++)
      step("post_rst", 3'b000, 1'b0, (i == 51) ? 3'b001 : 3'b000);
    empty_0 = 1'b1; write_enb_reg = 1'b0;
    step("idle_e", 3'b000, 1'b0, 3'b000);
    drv_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!(drv_done && sb.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: %0d expectations pending, required 0", sb.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
